ahb3lite_dma_master_arb: RTL and testbench

Two-port AHB3-Lite master arbiter that shares one AHB3-Lite master bus between the DMA core's two bridged master interfaces (m0 and m1). It sits between the DMA wrapper and the system interconnect. It arbitrates only at transfer and burst boundaries, keeps fixed-length bursts intact, and gives each port a one-entry address holding stage so that a losing master is stalled legally.

---
 rtl/ahb3lite_pkg.sv | 19 +
 rtl/ahb3lite_dma_arb_port.sv | 78 +++++++
 rtl/ahb3lite_dma_master_arb.sv | 197 +++++++++++++++++++
 tb/tb_ahb3lite_dma_master_arb.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite encodings shared by the DMA master arbiter and its port slices.
package ahb3lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   // NONSEQ and SEQ carry an address; IDLE and BUSY do not.
   function automatic logic htrans_active(input logic [1:0] t);
      return t[1];
   endfunction

endpackage

// File: rtl/ahb3lite_dma_arb_port.sv
// One upstream port slice: a single-entry address hold register that parks a
// losing master's address phase, the live/held source mux and the request flag.
module ahb3lite_dma_arb_port
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE = 32
)(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  hsel_i,
   input  logic [HADDR_SIZE-1:0] haddr_i,
   input  logic                  hwrite_i,
   input  logic [2:0]            hsize_i,
   input  logic [2:0]            hburst_i,
   input  logic [3:0]            hprot_i,
   input  logic [1:0]            htrans_i,
   input  logic                  hready_i,   // this port's own HREADY towards its master
   input  logic                  grant_i,    // this port's source was accepted on the bus
   output logic [HADDR_SIZE-1:0] src_haddr_o,
   output logic                  src_hwrite_o,
   output logic [2:0]            src_hsize_o,
   output logic [2:0]            src_hburst_o,
   output logic [3:0]            src_hprot_o,
   output logic [1:0]            src_htrans_o,
   output logic                  req_o,
   output logic                  hold_vld_o
);

   logic                  hold_vld_q;
   logic [HADDR_SIZE-1:0] hold_haddr_q;
   logic                  hold_hwrite_q;
   logic [2:0]            hold_hsize_q;
   logic [2:0]            hold_hburst_q;
   logic [3:0]            hold_hprot_q;
   logic [1:0]            hold_htrans_q;
   logic                  live_req;
   logic                  capture;

   // A master that has deselected the bus is not requesting it.
   assign live_req = hsel_i & htrans_active(htrans_i);

   // The master saw HREADY high, so its address phase ends this cycle; park it
   // unless the bus is taking it right now.
   assign capture  = hready_i & live_req & ~hold_vld_q & ~grant_i;

   // Hold valid flag: set on capture, dropped once the held address is accepted.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hold_vld_q <= 1'b0;
      end else if (capture) begin
         hold_vld_q <= 1'b1;
      end else if (grant_i && hold_vld_q) begin
         hold_vld_q <= 1'b0;
      end
   end

   // Held address-phase fields; only meaningful while hold_vld_q is set.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         hold_haddr_q  <= haddr_i;
         hold_hwrite_q <= hwrite_i;
         hold_hsize_q  <= hsize_i;
         hold_hburst_q <= hburst_i;
         hold_hprot_q  <= hprot_i;
         hold_htrans_q <= htrans_i;
      end
   end

   assign src_haddr_o  = hold_vld_q ? hold_haddr_q  : haddr_i;
   assign src_hwrite_o = hold_vld_q ? hold_hwrite_q : hwrite_i;
   assign src_hsize_o  = hold_vld_q ? hold_hsize_q  : hsize_i;
   assign src_hburst_o = hold_vld_q ? hold_hburst_q : hburst_i;
   assign src_hprot_o  = hold_vld_q ? hold_hprot_q  : hprot_i;
   assign src_htrans_o = hold_vld_q ? hold_htrans_q : htrans_i;
   assign req_o        = hold_vld_q ? htrans_active(hold_htrans_q) : live_req;
   assign hold_vld_o   = hold_vld_q;

endmodule

// File: rtl/ahb3lite_dma_master_arb.sv
// Two-port AHB3-Lite master arbiter sharing one master bus between the DMA
// core's m0/m1 interfaces. Arbitrates only at transfer/burst boundaries.
// Build option AHB3LITE_DMA_ARB_RR_EN: round-robin tie-break; when undefined
// port 0 always wins ties. Burst locking is identical in both builds.
module ahb3lite_dma_master_arb
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32
)(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  p0HSEL,
   input  logic [HADDR_SIZE-1:0] p0HADDR,
   input  logic [HDATA_SIZE-1:0] p0HWDATA,
   input  logic                  p0HWRITE,
   input  logic [2:0]            p0HSIZE,
   input  logic [2:0]            p0HBURST,
   input  logic [3:0]            p0HPROT,
   input  logic [1:0]            p0HTRANS,
   output logic [HDATA_SIZE-1:0] p0HRDATA,
   output logic                  p0HREADY,
   output logic                  p0HRESP,
   input  logic                  p1HSEL,
   input  logic [HADDR_SIZE-1:0] p1HADDR,
   input  logic [HDATA_SIZE-1:0] p1HWDATA,
   input  logic                  p1HWRITE,
   input  logic [2:0]            p1HSIZE,
   input  logic [2:0]            p1HBURST,
   input  logic [3:0]            p1HPROT,
   input  logic [1:0]            p1HTRANS,
   output logic [HDATA_SIZE-1:0] p1HRDATA,
   output logic                  p1HREADY,
   output logic                  p1HRESP,
   output logic                  mHSEL,
   output logic [HADDR_SIZE-1:0] mHADDR,
   output logic [HDATA_SIZE-1:0] mHWDATA,
   output logic                  mHWRITE,
   output logic [2:0]            mHSIZE,
   output logic [2:0]            mHBURST,
   output logic [3:0]            mHPROT,
   output logic [1:0]            mHTRANS,
   input  logic [HDATA_SIZE-1:0] mHRDATA,
   input  logic                  mHREADY,
   input  logic                  mHRESP,
   output logic                  mHREADYOUT
);

   logic [HADDR_SIZE-1:0] src_haddr  [2];
   logic                  src_hwrite [2];
   logic [2:0]            src_hsize  [2];
   logic [2:0]            src_hburst [2];
   logic [3:0]            src_hprot  [2];
   logic [1:0]            src_htrans [2];
   logic [1:0]            req;
   logic [1:0]            hold_vld;
   logic [1:0]            grant;

   logic last_owner_q, last_owner_d;
   logic data_owner_q, data_owner_d;
   logic data_valid_q, data_valid_d;
   logic burst_lock_q, burst_lock_d;
   logic lock_win;
   logic winner;
   logic accept;

   ahb3lite_dma_arb_port #(.HADDR_SIZE(HADDR_SIZE)) u_port0 (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .hsel_i       (p0HSEL),
      .haddr_i      (p0HADDR),
      .hwrite_i     (p0HWRITE),
      .hsize_i      (p0HSIZE),
      .hburst_i     (p0HBURST),
      .hprot_i      (p0HPROT),
      .htrans_i     (p0HTRANS),
      .hready_i     (p0HREADY),
      .grant_i      (grant[0]),
      .src_haddr_o  (src_haddr[0]),
      .src_hwrite_o (src_hwrite[0]),
      .src_hsize_o  (src_hsize[0]),
      .src_hburst_o (src_hburst[0]),
      .src_hprot_o  (src_hprot[0]),
      .src_htrans_o (src_htrans[0]),
      .req_o        (req[0]),
      .hold_vld_o   (hold_vld[0])
   );

   ahb3lite_dma_arb_port #(.HADDR_SIZE(HADDR_SIZE)) u_port1 (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .hsel_i       (p1HSEL),
      .haddr_i      (p1HADDR),
      .hwrite_i     (p1HWRITE),
      .hsize_i      (p1HSIZE),
      .hburst_i     (p1HBURST),
      .hprot_i      (p1HPROT),
      .htrans_i     (p1HTRANS),
      .hready_i     (p1HREADY),
      .grant_i      (grant[1]),
      .src_haddr_o  (src_haddr[1]),
      .src_hwrite_o (src_hwrite[1]),
      .src_hsize_o  (src_hsize[1]),
      .src_hburst_o (src_hburst[1]),
      .src_hprot_o  (src_hprot[1]),
      .src_htrans_o (src_htrans[1]),
      .req_o        (req[1]),
      .hold_vld_o   (hold_vld[1])
   );

   // Winner: a locked burst owner continuing with SEQ/BUSY keeps the bus,
   // otherwise the single requester, otherwise the tie-break.
   always_comb begin
      lock_win = burst_lock_q &&
                 ((src_htrans[last_owner_q] == HTRANS_SEQ) ||
                  (src_htrans[last_owner_q] == HTRANS_BUSY));
      winner   = last_owner_q;
      if (!lock_win) begin
         if (req[0] && req[1]) begin
`ifdef AHB3LITE_DMA_ARB_RR_EN
            winner = ~last_owner_q;
`else
            winner = 1'b0;
`endif
         end else if (req[0]) begin
            winner = 1'b0;
         end else if (req[1]) begin
            winner = 1'b1;
         end
      end
   end

   // Transfer type: IDLE under reset or with nobody to serve.
   always_comb begin
      mHTRANS = HTRANS_IDLE;
      if (rst_n_i && (lock_win || req[winner])) begin
         mHTRANS = src_htrans[winner];
      end
   end

   assign mHSEL      = mHTRANS[1];
   assign mHADDR     = src_haddr[winner];
   assign mHWRITE    = src_hwrite[winner];
   assign mHSIZE     = src_hsize[winner];
   assign mHBURST    = src_hburst[winner];
   assign mHPROT     = src_hprot[winner];
   assign mHWDATA    = data_owner_q ? p1HWDATA : p0HWDATA;
   assign mHREADYOUT = mHREADY;

   assign accept   = mHREADY & htrans_active(mHTRANS);
   assign grant[0] = accept & ~winner;
   assign grant[1] = accept &  winner;

   assign p0HRDATA = mHRDATA;
   assign p1HRDATA = mHRDATA;
   assign p0HREADY = (data_valid_q && !data_owner_q) ? mHREADY : ~hold_vld[0];
   assign p1HREADY = (data_valid_q &&  data_owner_q) ? mHREADY : ~hold_vld[1];
   assign p0HRESP  = (data_valid_q && !data_owner_q) ? mHRESP  : HRESP_OKAY;
   assign p1HRESP  = (data_valid_q &&  data_owner_q) ? mHRESP  : HRESP_OKAY;

   // Next state for ownership, data-phase tracking and burst lock.
   always_comb begin
      last_owner_d = last_owner_q;
      data_owner_d = data_owner_q;
      data_valid_d = data_valid_q;
      burst_lock_d = burst_lock_q;
      if (mHREADY) begin
         data_valid_d = accept;
      end
      if (accept) begin
         last_owner_d = winner;
         data_owner_d = winner;
      end
      if (accept && (mHTRANS == HTRANS_NONSEQ) && (mHBURST != HBURST_SINGLE)) begin
         burst_lock_d = 1'b1;
      end else if (mHREADY && ((src_htrans[last_owner_q] == HTRANS_IDLE) ||
                               (src_htrans[last_owner_q] == HTRANS_NONSEQ))) begin
         burst_lock_d = 1'b0;
      end
   end

   // Control state; last_owner resets to 1 so port 0 takes the first tie.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_owner_q <= 1'b1;
         data_owner_q <= 1'b0;
         data_valid_q <= 1'b0;
         burst_lock_q <= 1'b0;
      end else begin
         last_owner_q <= last_owner_d;
         data_owner_q <= data_owner_d;
         data_valid_q <= data_valid_d;
         burst_lock_q <= burst_lock_d;
      end
   end

endmodule

// File: tb/tb_ahb3lite_dma_master_arb.sv
// Directed bench for ahb3lite_dma_master_arb; the bus slave is driven by hand.
// Expectations for the tie-break follow AHB3LITE_DMA_ARB_RR_EN.
module tb_ahb3lite_dma_master_arb;
   import ahb3lite_pkg::*;

   localparam logic [2:0] INCR4 = 3'b011;

   logic        clk_i;
   logic        rst_n_i;
   logic        p0HSEL, p1HSEL;
   logic [31:0] p0HADDR, p1HADDR, p0HWDATA, p1HWDATA;
   logic        p0HWRITE, p1HWRITE;
   logic [2:0]  p0HSIZE, p1HSIZE, p0HBURST, p1HBURST;
   logic [3:0]  p0HPROT, p1HPROT;
   logic [1:0]  p0HTRANS, p1HTRANS;
   logic [31:0] p0HRDATA, p1HRDATA;
   logic        p0HREADY, p1HREADY, p0HRESP, p1HRESP;
   logic        mHSEL;
   logic [31:0] mHADDR, mHWDATA, mHRDATA;
   logic        mHWRITE;
   logic [2:0]  mHSIZE, mHBURST;
   logic [3:0]  mHPROT;
   logic [1:0]  mHTRANS;
   logic        mHREADY, mHRESP, mHREADYOUT;

   int total = 0;
   int bad   = 0;
   int k;
   logic [31:0] b2b_exp [5];

   ahb3lite_dma_master_arb #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .p0HSEL(p0HSEL), .p0HADDR(p0HADDR), .p0HWDATA(p0HWDATA), .p0HWRITE(p0HWRITE),
      .p0HSIZE(p0HSIZE), .p0HBURST(p0HBURST), .p0HPROT(p0HPROT), .p0HTRANS(p0HTRANS),
      .p0HRDATA(p0HRDATA), .p0HREADY(p0HREADY), .p0HRESP(p0HRESP),
      .p1HSEL(p1HSEL), .p1HADDR(p1HADDR), .p1HWDATA(p1HWDATA), .p1HWRITE(p1HWRITE),
      .p1HSIZE(p1HSIZE), .p1HBURST(p1HBURST), .p1HPROT(p1HPROT), .p1HTRANS(p1HTRANS),
      .p1HRDATA(p1HRDATA), .p1HREADY(p1HREADY), .p1HRESP(p1HRESP),
      .mHSEL(mHSEL), .mHADDR(mHADDR), .mHWDATA(mHWDATA), .mHWRITE(mHWRITE),
      .mHSIZE(mHSIZE), .mHBURST(mHBURST), .mHPROT(mHPROT), .mHTRANS(mHTRANS),
      .mHRDATA(mHRDATA), .mHREADY(mHREADY), .mHRESP(mHRESP), .mHREADYOUT(mHREADYOUT)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drv(input bit p, input logic [1:0] tr, input logic [31:0] a,
                      input logic w, input logic [2:0] b);
      if (!p) begin
         p0HSEL = (tr != HTRANS_IDLE); p0HTRANS = tr; p0HADDR = a; p0HWRITE = w;
         p0HBURST = b; p0HSIZE = 3'b010; p0HPROT = 4'b0011;
      end else begin
         p1HSEL = (tr != HTRANS_IDLE); p1HTRANS = tr; p1HADDR = a; p1HWRITE = w;
         p1HBURST = b; p1HSIZE = 3'b010; p1HPROT = 4'b0011;
      end
   endtask

   task automatic idle_all();
      drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      drv(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   task automatic rst_pulse();
      nxt();
      rst_n_i = 1'b0;
      idle_all();
      nxt();
      rst_n_i = 1'b1;
   endtask

   initial begin
`ifdef AHB3LITE_DMA_ARB_RR_EN
      b2b_exp[0] = 32'h100; b2b_exp[1] = 32'h200; b2b_exp[2] = 32'h104;
      b2b_exp[3] = 32'h108; b2b_exp[4] = 32'h10C;
`else
      b2b_exp[0] = 32'h100; b2b_exp[1] = 32'h104; b2b_exp[2] = 32'h108;
      b2b_exp[3] = 32'h10C; b2b_exp[4] = 32'h200;
`endif
      rst_n_i = 1'b0; mHREADY = 1'b1; mHRESP = HRESP_OKAY; mHRDATA = 32'h0;
      p0HWDATA = 32'h0; p1HWDATA = 32'h0;
      idle_all();

      // reset state, with a request already present
      drv(1'b0, HTRANS_NONSEQ, 32'h1000, 1'b1, HBURST_SINGLE);
      #2;
      chk("rst_htrans", 32'(mHTRANS), 32'(HTRANS_IDLE));
      chk("rst_hsel",   32'(mHSEL), 32'd0);
      chk("rst_p0rdy",  32'(p0HREADY), 32'd1);
      chk("rst_p1rdy",  32'(p1HREADY), 32'd1);
      chk("rst_p0resp", 32'(p0HRESP), 32'd0);
      chk("rst_p1resp", 32'(p1HRESP), 32'd0);
      idle_all();
      nxt();
      rst_n_i = 1'b1;

      // single write, idle neighbour
      nxt();
      drv(1'b0, HTRANS_NONSEQ, 32'h1000, 1'b1, HBURST_SINGLE);
      #1;
      chk("wr_addr",   mHADDR, 32'h1000);
      chk("wr_trans",  32'(mHTRANS), 32'(HTRANS_NONSEQ));
      chk("wr_write",  32'(mHWRITE), 32'd1);
      chk("wr_hsel",   32'(mHSEL), 32'd1);
      chk("wr_p0rdy",  32'(p0HREADY), 32'd1);
      nxt();
      idle_all();
      p0HWDATA = 32'hCAFEBABE;
      mHREADY = 1'b0;
      #1;
      chk("wr_wdata",     mHWDATA, 32'hCAFEBABE);
      chk("wr_p0rdy_lo",  32'(p0HREADY), 32'd0);
      mHREADY = 1'b1;
      #1;
      chk("wr_p0rdy_hi",  32'(p0HREADY), 32'd1);
      chk("wr_p1rdy",     32'(p1HREADY), 32'd1);
      chk("wr_readyout",  32'(mHREADYOUT), 32'd1);

      // simultaneous singles after reset
      rst_pulse();
      nxt();
      drv(1'b0, HTRANS_NONSEQ, 32'h10, 1'b0, HBURST_SINGLE);
      drv(1'b1, HTRANS_NONSEQ, 32'h20, 1'b0, HBURST_SINGLE);
      #1;
      chk("tie1_addr",  mHADDR, 32'h10);
      chk("tie1_p1rdy", 32'(p1HREADY), 32'd1);
      nxt();
      idle_all();
      mHRDATA = 32'h11111111;
      #1;
      chk("hold_addr",   mHADDR, 32'h20);
      chk("hold_trans",  32'(mHTRANS), 32'(HTRANS_NONSEQ));
      chk("hold_p1rdy",  32'(p1HREADY), 32'd0);
      chk("hold_p0rdy",  32'(p0HREADY), 32'd1);
      chk("hold_p0rdat", p0HRDATA, 32'h11111111);
      nxt();
      #1;
      chk("hold_done_p1rdy", 32'(p1HREADY), 32'd1);
      chk("hold_done_trans", 32'(mHTRANS), 32'(HTRANS_IDLE));
      nxt();
      drv(1'b0, HTRANS_NONSEQ, 32'h30, 1'b0, HBURST_SINGLE);
      drv(1'b1, HTRANS_NONSEQ, 32'h40, 1'b0, HBURST_SINGLE);
      #1;
      chk("tie2_addr", mHADDR, 32'h30);
      nxt();
      idle_all();
      #1;
      chk("tie2_p1_addr", mHADDR, 32'h40);
      nxt();
      nxt();

      // back-to-back ties: p0 keeps issuing, p1 issues once
      k = 0;
      for (int c = 0; c < 5; c++) begin
         nxt();
         if (k < 4) drv(1'b0, HTRANS_NONSEQ, 32'h100 + 32'(4 * k), 1'b0, HBURST_SINGLE);
         else       drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
         if (c == 0) drv(1'b1, HTRANS_NONSEQ, 32'h200, 1'b0, HBURST_SINGLE);
         else        drv(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
         #1;
         chk($sformatf("b2b_addr%0d", c), mHADDR, b2b_exp[c]);
         chk($sformatf("b2b_trans%0d", c), 32'(mHTRANS), 32'(HTRANS_NONSEQ));
         if (k < 4 && p0HREADY) k++;
      end
      nxt();
      idle_all();
      nxt();

      // burst kept intact while p1 requests during beat 2
      nxt();
      drv(1'b0, HTRANS_NONSEQ, 32'h2000, 1'b0, INCR4);
      #1;
      chk("burst_b0", mHADDR, 32'h2000);
      nxt();
      drv(1'b0, HTRANS_SEQ, 32'h2004, 1'b0, INCR4);
      drv(1'b1, HTRANS_NONSEQ, 32'h3000, 1'b0, HBURST_SINGLE);
      #1;
      chk("burst_b1", mHADDR, 32'h2004);
      chk("burst_p1rdy_b1", 32'(p1HREADY), 32'd1);
      nxt();
      drv(1'b0, HTRANS_SEQ, 32'h2008, 1'b0, INCR4);
      drv(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      #1;
      chk("burst_b2", mHADDR, 32'h2008);
      chk("burst_p1rdy_b2", 32'(p1HREADY), 32'd0);
      nxt();
      drv(1'b0, HTRANS_SEQ, 32'h200C, 1'b0, INCR4);
      #1;
      chk("burst_b3", mHADDR, 32'h200C);
      chk("burst_p1rdy_b3", 32'(p1HREADY), 32'd0);
      nxt();
      drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      #1;
      chk("burst_p1_addr",  mHADDR, 32'h3000);
      chk("burst_p1_trans", 32'(mHTRANS), 32'(HTRANS_NONSEQ));
      nxt();
      #1;
      chk("burst_p1_done", 32'(p1HREADY), 32'd1);
      nxt();

      // wait states on p1's data phase while p0 requests
      nxt();
      drv(1'b1, HTRANS_NONSEQ, 32'h4000, 1'b0, HBURST_SINGLE);
      #1;
      chk("ws_p1_addr", mHADDR, 32'h4000);
      nxt();
      drv(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      drv(1'b0, HTRANS_NONSEQ, 32'h5000, 1'b1, HBURST_SINGLE);
      mHREADY = 1'b0;
      #1;
      chk("ws1_addr",  mHADDR, 32'h5000);
      chk("ws1_p1rdy", 32'(p1HREADY), 32'd0);
      chk("ws1_p0rdy", 32'(p0HREADY), 32'd1);
      nxt();
      drv(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      #1;
      chk("ws2_p1rdy", 32'(p1HREADY), 32'd0);
      chk("ws2_p0rdy", 32'(p0HREADY), 32'd0);
      chk("ws2_addr",  mHADDR, 32'h5000);
      nxt();
      mHREADY = 1'b1;
      mHRDATA = 32'hDEADBEEF;
      #1;
      chk("ws3_p1rdy",  32'(p1HREADY), 32'd1);
      chk("ws3_p1rdat", p1HRDATA, 32'hDEADBEEF);
      chk("ws3_p0rdy",  32'(p0HREADY), 32'd0);
      chk("ws3_addr",   mHADDR, 32'h5000);
      nxt();
      #1;
      chk("ws4_p0rdy",  32'(p0HREADY), 32'd1);
      chk("ws4_trans",  32'(mHTRANS), 32'(HTRANS_IDLE));
      nxt();

      // ERROR response isolated to p0
      nxt();
      drv(1'b0, HTRANS_NONSEQ, 32'h6000, 1'b1, HBURST_SINGLE);
      #1;
      chk("err_addr", mHADDR, 32'h6000);
      nxt();
      idle_all();
      mHREADY = 1'b0;
      mHRESP = HRESP_ERROR;
      #1;
      chk("err1_p0resp", 32'(p0HRESP), 32'd1);
      chk("err1_p0rdy",  32'(p0HREADY), 32'd0);
      chk("err1_p1resp", 32'(p1HRESP), 32'd0);
      chk("err1_p1rdy",  32'(p1HREADY), 32'd1);
      nxt();
      mHREADY = 1'b1;
      #1;
      chk("err2_p0resp", 32'(p0HRESP), 32'd1);
      chk("err2_p0rdy",  32'(p0HREADY), 32'd1);
      chk("err2_p1resp", 32'(p1HRESP), 32'd0);
      nxt();
      mHRESP = HRESP_OKAY;
      #1;
      chk("err3_p0resp", 32'(p0HRESP), 32'd0);

      // reset mid-burst with p1 parked in its hold register
      nxt();
      drv(1'b0, HTRANS_NONSEQ, 32'h7000, 1'b0, INCR4);
      nxt();
      drv(1'b0, HTRANS_SEQ, 32'h7004, 1'b0, INCR4);
      drv(1'b1, HTRANS_NONSEQ, 32'h8000, 1'b0, HBURST_SINGLE);
      #1;
      chk("mrst_b1", mHADDR, 32'h7004);
      nxt();
      drv(1'b0, HTRANS_SEQ, 32'h7008, 1'b0, INCR4);
      drv(1'b1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE);
      #1;
      chk("mrst_b2",        mHADDR, 32'h7008);
      chk("mrst_b2_trans",  32'(mHTRANS), 32'(HTRANS_SEQ));
      chk("mrst_pre_p1rdy", 32'(p1HREADY), 32'd0);
      rst_n_i = 1'b0;
      #1;
      chk("mrst_trans", 32'(mHTRANS), 32'(HTRANS_IDLE));
      chk("mrst_hsel",  32'(mHSEL), 32'd0);
      chk("mrst_p0rdy", 32'(p0HREADY), 32'd1);
      chk("mrst_p1rdy", 32'(p1HREADY), 32'd1);
      nxt();
      rst_n_i = 1'b1;
      idle_all();
      #1;
      chk("mrst_post_trans", 32'(mHTRANS), 32'(HTRANS_IDLE));
      chk("mrst_post_p1rdy", 32'(p1HREADY), 32'd1);
      nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
